// File: rtl/aes_result_collector.sv
// Result-side buffer for the AES round pipeline: captures unstallable result beats,
// queues them for the host, and returns issue credit to the input feeder.
module aes_result_collector #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 128,
   parameter int ID_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pkt_valid,
   input  logic [DATA_W-1:0]          pkt_data,
   input  logic [ID_W-1:0]            pkt_id,
   input  logic                       issue,
   output logic                       can_issue,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [ID_W-1:0]            out_id,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic                       err_overflow,
   output logic                       err_orphan
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [ID_W-1:0]   id_mem   [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [CNT_W-1:0]  occ_cnt;
   logic [CNT_W-1:0]  inflight_cnt;
   logic              push;
   logic              push_acc;
   logic              pop;
   logic [CNT_W:0]    credit_sum;

   // Saturating inflight update: never below 0 on an orphan beat, never above DEPTH.
   function automatic logic [CNT_W-1:0] inflight_next(input logic [CNT_W-1:0] cur,
                                                       input logic             inc,
                                                       input logic             dec);
      logic dec_eff;
      logic inc_eff;
      dec_eff = dec && (cur != '0);
      inc_eff = inc && ((cur != FULL) || dec_eff);
      return cur + CNT_W'(inc_eff) - CNT_W'(dec_eff);
   endfunction

   assign out_valid  = (occ_cnt != '0);
   assign pop        = out_valid && out_ready;
   assign push       = pkt_valid && ((occ_cnt < FULL) || pop);
   assign push_acc   = push && !flush;
   assign credit_sum = {1'b0, occ_cnt} + {1'b0, inflight_cnt};
   assign can_issue  = (credit_sum < {1'b0, FULL});
   assign occupancy  = occ_cnt;
   assign inflight   = inflight_cnt;
   assign out_data   = out_valid ? data_mem[rptr] : '0;
   assign out_id     = out_valid ? id_mem[rptr]   : '0;

   // Payload storage carries no reset; out_data/out_id are masked while empty.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         data_mem[wptr] <= pkt_data;
         id_mem[wptr]   <= pkt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         occ_cnt <= '0;
      end else if (flush) begin
         rptr    <= wptr;
         occ_cnt <= '0;
      end else begin
         if (push_acc) wptr <= wptr + 1'b1;
         if (pop)      rptr <= rptr + 1'b1;
         occ_cnt <= occ_cnt + CNT_W'(push_acc) - CNT_W'(pop);
      end
   end

   // Flush leaves inflight alone: launched blocks still come back and get stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_cnt <= '0;
         err_overflow <= 1'b0;
         err_orphan   <= 1'b0;
      end else begin
         inflight_cnt <= inflight_next(inflight_cnt, issue, pkt_valid);
         if (pkt_valid && (occ_cnt == FULL) && !pop) err_overflow <= 1'b1;
         if (pkt_valid && (inflight_cnt == '0))      err_orphan   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_result_collector.sv
// Directed bench for aes_result_collector: latency, credit limit, full/overflow,
// ordering under backpressure, flush with blocks in flight, asynchronous reset.
module tb_aes_result_collector;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 128;
   localparam int ID_W   = 4;
   localparam int CW     = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              pkt_valid;
   logic [DATA_W-1:0] pkt_data;
   logic [ID_W-1:0]   pkt_id;
   logic              issue;
   logic              can_issue;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ID_W-1:0]   out_id;
   logic              flush;
   logic [CW-1:0]     occupancy;
   logic [CW-1:0]     inflight;
   logic              err_overflow;
   logic              err_orphan;

   int checks   = 0;
   int failures = 0;

   aes_result_collector #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
      .pkt_id(pkt_id), .issue(issue), .can_issue(can_issue), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_id(out_id), .flush(flush),
      .occupancy(occupancy), .inflight(inflight), .err_overflow(err_overflow),
      .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   function automatic logic [127:0] dat(input int i);
      return 128'h0123_4567_89ab_cdef_0000_0000_0000_0000 | 128'(i);
   endfunction

   localparam logic [127:0] VEC1  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] DAT_X = 128'hfeed_face_cafe_beef_1234_5678_9abc_def0;

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

   initial begin
      int n_iss, i16, i0, exp_id, c;
      rst_n = 1'b0; pkt_valid = 1'b0; pkt_data = '0; pkt_id = '0;
      issue = 1'b0; out_ready = 1'b0; flush = 1'b0;
      #12;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_occupancy", 128'(occupancy), 128'(0));
      check("rst_inflight",  128'(inflight),  128'(0));
      check("rst_can_issue", 128'(can_issue), 128'(1));
      check("rst_err_ovf",   128'(err_overflow), 128'(0));
      check("rst_err_orph",  128'(err_orphan),   128'(0));
      check("rst_out_data",  out_data, 128'(0));
      check("rst_out_id",    128'(out_id), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Single block through the 11-cycle engine latency
      tick;
      issue = 1'b1;
      tick;
      issue = 1'b0;
      check("single_inflight1", 128'(inflight), 128'(1));
      repeat (10) tick;
      pkt_valid = 1'b1; pkt_data = VEC1; pkt_id = 4'd5; out_ready = 1'b1;
      tick;
      pkt_valid = 1'b0;
      check("single_valid", 128'(out_valid), 128'(1));
      check("single_data",  out_data, VEC1);
      check("single_id",    128'(out_id), 128'(5));
      check("single_inflight0", 128'(inflight), 128'(0));
      tick;
      out_ready = 1'b0;
      check("single_occ0",   128'(occupancy), 128'(0));
      check("single_empty",  128'(out_valid), 128'(0));

      // Credit limit with the host stalled
      n_iss = 0; i16 = -1; i0 = -1;
      for (int k = 0; k < 20; k++) begin
         issue = can_issue;
         if (!can_issue && i0 < 0) i0 = k;
         if (can_issue) begin
            n_iss++;
            if (n_iss == 16) i16 = k;
         end
         tick;
      end
      issue = 1'b0;
      check("credit_issues", 128'(n_iss), 128'(16));
      check("credit_fall_cycle", 128'(i0), 128'(i16 + 1));
      check("credit_inflight16", 128'(inflight), 128'(16));
      for (int k = 0; k < 16; k++) begin
         pkt_valid = 1'b1; pkt_data = dat(k); pkt_id = ID_W'(k);
         tick;
      end
      pkt_valid = 1'b0;
      check("credit_occ16",     128'(occupancy), 128'(16));
      check("credit_inflight0", 128'(inflight),  128'(0));
      check("credit_no_issue",  128'(can_issue), 128'(0));
      check("credit_err_ovf",   128'(err_overflow), 128'(0));
      check("credit_err_orph",  128'(err_orphan),   128'(0));
      check("credit_head_id",   128'(out_id), 128'(0));

      // Issue without credit: counter rises, no credit granted
      issue = 1'b1;
      tick;
      issue = 1'b0;
      check("ovr_issue_inflight", 128'(inflight), 128'(1));
      check("ovr_issue_can",      128'(can_issue), 128'(0));

      // Full with simultaneous pop still accepts the beat
      pkt_valid = 1'b1; pkt_data = DAT_X; pkt_id = 4'd9; out_ready = 1'b1;
      tick;
      pkt_valid = 1'b0; out_ready = 1'b0;
      check("fullpop_occ",      128'(occupancy), 128'(16));
      check("fullpop_err_ovf",  128'(err_overflow), 128'(0));
      check("fullpop_err_orph", 128'(err_orphan),   128'(0));
      check("fullpop_head_id",  128'(out_id), 128'(1));

      // Full, no pop, nothing in flight: dropped beat, both errors
      pkt_valid = 1'b1; pkt_data = 128'hdead; pkt_id = 4'd3;
      tick;
      pkt_valid = 1'b0;
      check("ovf_err_ovf",   128'(err_overflow), 128'(1));
      check("ovf_err_orph",  128'(err_orphan),   128'(1));
      check("ovf_occ",       128'(occupancy), 128'(16));
      check("ovf_head_id",   128'(out_id), 128'(1));
      check("ovf_head_data", out_data, dat(1));

      // Drain: ids 1..15 then the tail beat from the full+pop cycle
      out_ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         check("drain_id",   128'(out_id), (k < 16) ? 128'(k) : 128'(9));
         check("drain_data", out_data, (k < 16) ? dat(k) : DAT_X);
         tick;
      end
      out_ready = 1'b0;
      check("drain_empty", 128'(out_valid), 128'(0));
      check("drain_occ0",  128'(occupancy), 128'(0));
      check("err_sticky",  128'(err_overflow), 128'(1));

      rst_n = 1'b0;
      #1;
      check("rst2_err_ovf",  128'(err_overflow), 128'(0));
      check("rst2_err_orph", 128'(err_orphan),   128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Ordering under random backpressure
      exp_id = 0; c = 0;
      while (!(exp_id == 8 && c >= 16) && c < 300) begin
         if (out_valid) begin
            check("bp_id",   128'(out_id), 128'(exp_id));
            check("bp_data", out_data, dat(exp_id + 32));
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) exp_id++;
         issue     = (c < 8);
         pkt_valid = (c >= 8 && c < 16);
         pkt_id    = ID_W'(c - 8);
         pkt_data  = dat(c - 8 + 32);
         tick;
         c++;
      end
      issue = 1'b0; pkt_valid = 1'b0; out_ready = 1'b0;
      check("bp_all_seen", 128'(exp_id), 128'(8));
      check("bp_occ0",     128'(occupancy), 128'(0));
      check("bp_no_err",   128'({err_overflow, err_orphan}), 128'(0));

      // Flush with blocks in flight
      issue = 1'b1;
      repeat (7) tick;
      issue = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pkt_valid = 1'b1; pkt_data = dat(k + 64); pkt_id = ID_W'(k);
         tick;
      end
      pkt_valid = 1'b0;
      check("pre_flush_occ", 128'(occupancy), 128'(4));
      check("pre_flush_inf", 128'(inflight),  128'(3));
      flush = 1'b1;
      tick;
      flush = 1'b0;
      check("flush_occ",   128'(occupancy), 128'(0));
      check("flush_inf",   128'(inflight),  128'(3));
      check("flush_valid", 128'(out_valid), 128'(0));
      check("flush_can",   128'(can_issue), 128'(1));
      for (int k = 0; k < 3; k++) begin
         pkt_valid = 1'b1; pkt_data = dat(k + 80); pkt_id = ID_W'(k + 10);
         tick;
      end
      pkt_valid = 1'b0;
      check("post_flush_occ", 128'(occupancy), 128'(3));
      check("post_flush_inf", 128'(inflight),  128'(0));
      out_ready = 1'b1;
      check("post_flush_id10", 128'(out_id), 128'(10));
      check("post_flush_d10",  out_data, dat(80));
      tick;
      check("post_flush_id11", 128'(out_id), 128'(11));
      tick;
      out_ready = 1'b0;
      check("post_flush_id12", 128'(out_id), 128'(12));
      check("post_flush_occ1", 128'(occupancy), 128'(1));

      // Asynchronous reset in mid-cycle
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_occ",   128'(occupancy), 128'(0));
      check("arst_valid", 128'(out_valid), 128'(0));
      check("arst_data",  out_data, 128'(0));
      check("arst_inf",   128'(inflight),  128'(0));
      check("arst_can",   128'(can_issue), 128'(1));
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
